spi_slave_only_rx_single_cs: RTL and testbench
==============================================

Name: spi_slave_only_rx_single_cs

Overview:
Receive-only SPI slave with a single active-low chip select. It recovers bytes sent by an external SPI master (SCLK/MOSI/CS), oversampling all three lines with the system clock. Each completed byte is presented as a parallel word with a one-cycle valid strobe. It is the receiving end of the team's transmit-only SPI master link, used for loopback tests and for the register-load path from an external controller.

Parameters:
SPI_MODE, 0, SPI mode 0..3. CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]. Must match the transmitting master.
SYNC_STAGES, 2, synchronizer flops per input line. Legal values 2..3.

Ports:
clk_i  input  1  system clock; all logic is on the rising edge
rst_i  input  1  synchronous reset, active-high
spi_clk_i  input  1  SCLK from the master; asynchronous to clk_i
spi_mosi_i  input  1  MOSI from the master; MSB first
spi_cs_i  input  1  chip select from the master, active-low
data_o  output  8  last completed byte; holds its value until the next byte completes
data_out_valid_strobe_o  output  1  one-cycle pulse when data_o updates
frame_active_o  output  1  high while in RECEIVE
byte_count_o  output  8  bytes completed in the current or last frame; saturates at 255
frame_error_strobe_o  output  1  one-cycle pulse when CS deasserts mid-byte

Behaviour:
- Synchronization: SCLK, MOSI and CS each pass through SYNC_STAGES flops, plus one history flop each on SCLK and CS for edge detection.
  - Reset values: SCLK chain = CPOL, CS chain = 1, MOSI chain = 0.
- Sample edge:
  - Rising SCLK edge when CPOL == CPHA (modes 0, 3).
  - Falling SCLK edge otherwise (modes 1, 2).
  - Shift edges are ignored.
  - MOSI is taken from the last sync stage in the same cycle the edge is detected.
- Timing constraint: each SCLK half-period and the CS setup time must be at least 2 clk_i periods. Below that, behaviour is undefined.
- State machine, 2 states:
  - IDLE: frame_active_o = 0. On a synced CS falling edge: go to RECEIVE, clear the shift register and bit counter (3 bits), clear byte_count_o.
  - RECEIVE: frame_active_o = 1. On each sample edge: shift = {shift[6:0], mosi}, bit_cnt + 1.
    - When bit_cnt == 7 at a sample edge: data_o <= {shift[6:0], mosi}, data_out_valid_strobe_o = 1 for one cycle, bit_cnt <= 0, byte_count_o + 1 (saturating).
  - RECEIVE -> IDLE on a synced CS rising edge.
    - If bit_cnt != 0 at that point: frame_error_strobe_o = 1 for one cycle and the partial byte is discarded.
    - data_o and byte_count_o keep their values.
- Latency: let clk_i edge k be the first to capture the new SCLK level. With SYNC_STAGES = 2, data_o and the strobe are valid after clk_i edge k+2. Each extra sync stage adds one cycle.
- Simultaneous events:
  - CS rising detected in the same cycle as a sample edge: CS wins, the edge is ignored, and the error rule applies.
  - A sample edge in the same cycle as the CS falling edge is ignored.
- SCLK or MOSI activity while in IDLE (CS high) has no effect on any output.
- Reset values, including reset mid-frame: state IDLE, data_o = 0x00, data_out_valid_strobe_o = 0, frame_active_o = 0, byte_count_o = 0, frame_error_strobe_o = 0, shift/bit_cnt = 0.
  - If CS is still low when reset is released, the block stays in IDLE until CS goes high and then low again. No byte from the interrupted frame is ever reported.
- Strobes are never asserted during reset or in the cycle reset is released.

Test Plan:
- Mode 0, SCLK = clk_i/8, CS low, byte 0xA5, CS high -> exactly one strobe, data_o = 0xA5, byte_count_o = 1, no error, frame_active_o falls 2-3 cycles after CS rises.
- Mode 0, one frame of 0x3C then 0xC3 -> two strobes, data_o = 0x3C then 0xC3, byte_count_o = 2, strobe latency = 3 clk_i cycles after the 8th rising SCLK edge.
- Mode 3 (idle-high SCLK), byte 0x81, then repeat in mode 1 and mode 2 builds -> data_o = 0x81 in each mode, one strobe each.
- Mode 0, 5 bits (10110) then CS high -> frame_error_strobe_o pulses once, no data strobe. The next full frame with 0x7E yields 0x7E, proving bit_cnt was cleared.
- CS held high, 16 SCLK toggles with random MOSI -> all outputs unchanged, no strobes.
- Reset pulsed after bit 4 of 0xFF with CS kept low, 4 more bits sent, then CS high -> no strobe and no error after reset. A following frame of 0x12 yields data_o = 0x12, byte_count_o = 1.

Source files
------------

// File: rtl/spi_slave_only_rx_single_cs_if.sv
// Bus bundle for the receive-only SPI slave: the three SPI lines from the
// external master plus the parallel-byte side presented to the core.
interface spi_slave_only_rx_single_cs_if;
  logic       spi_clk_i;
  logic       spi_mosi_i;
  logic       spi_cs_i;
  logic [7:0] data_o;
  logic       data_out_valid_strobe_o;
  logic       frame_active_o;
  logic [7:0] byte_count_o;
  logic       frame_error_strobe_o;

  // Side that drives the SPI lines and watches the received bytes.
  modport master (
    output spi_clk_i,
    output spi_mosi_i,
    output spi_cs_i,
    input  data_o,
    input  data_out_valid_strobe_o,
    input  frame_active_o,
    input  byte_count_o,
    input  frame_error_strobe_o
  );

  // Side implemented by the SPI slave receiver.
  modport slave (
    input  spi_clk_i,
    input  spi_mosi_i,
    input  spi_cs_i,
    output data_o,
    output data_out_valid_strobe_o,
    output frame_active_o,
    output byte_count_o,
    output frame_error_strobe_o
  );
endinterface

// File: rtl/spi_slave_only_rx_single_cs.sv
// Receive-only SPI slave with one active-low chip select. SCLK, MOSI and CS
// are oversampled by clk_i; completed bytes are presented in parallel with a
// one-cycle strobe, and a CS release in the middle of a byte is flagged.
module spi_slave_only_rx_single_cs #(
  parameter int unsigned SPI_MODE    = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  spi_slave_only_rx_single_cs_if.slave  bus
);

  localparam logic [1:0] MODE_BITS     = SPI_MODE[1:0];
  localparam logic       CPOL          = MODE_BITS[1];
  localparam logic       CPHA          = MODE_BITS[0];
  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
  localparam logic       SAMPLE_RISING = (CPOL == CPHA);
  localparam logic [1:0] FLUSH_DONE    = 2'(SYNC_STAGES);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RECEIVE = 1'b1
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;

  logic [SYNC_STAGES-1:0]  sclk_sync_reg;
  logic [SYNC_STAGES-1:0]  mosi_sync_reg;
  logic [SYNC_STAGES-1:0]  cs_sync_reg;
  logic                    sclk_hist_reg;
  logic                    cs_hist_reg;

  // Counts clk_i cycles after reset until every sync stage holds a real sample.
  logic [1:0]              flush_cnt_reg;
  // Set once CS has been seen high after reset; a frame already in progress
  // when reset was released must not be picked up half way.
  logic                    armed_reg;

  logic [7:0]              shift_reg;
  logic [2:0]              bit_cnt_reg;
  logic [7:0]              data_reg;
  logic                    data_vld_reg;
  logic [7:0]              byte_count_reg;
  logic                    frame_err_reg;
  logic                    frame_active;

  logic                    sclk_s;
  logic                    mosi_s;
  logic                    cs_s;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    sample_edge;
  logic                    cs_fall;
  logic                    cs_rise;
  logic                    frame_start;
  logic                    flush_done;

  assign sclk_s      = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_s        = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_hist_reg;
  assign sclk_fall   = ~sclk_s & sclk_hist_reg;
  assign sample_edge = SAMPLE_RISING ? sclk_rise : sclk_fall;
  assign cs_fall     = ~cs_s & cs_hist_reg;
  assign cs_rise     = cs_s & ~cs_hist_reg;
  assign flush_done  = (flush_cnt_reg == FLUSH_DONE);
  assign frame_start = cs_fall & armed_reg;

  // Synchronizer chains plus one history flop on SCLK and CS for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_reg <= {SYNC_STAGES{CPOL}};
      mosi_sync_reg <= '0;
      cs_sync_reg   <= '1;
      sclk_hist_reg <= CPOL;
      cs_hist_reg   <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], bus.spi_clk_i};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], bus.spi_mosi_i};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], bus.spi_cs_i};
      sclk_hist_reg <= sclk_s;
      cs_hist_reg   <= cs_s;
    end
  end

  // Arm frame detection only after CS has genuinely been observed high post-reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_cnt_reg <= '0;
      armed_reg     <= 1'b0;
    end else begin
      if (!flush_done) begin
        flush_cnt_reg <= flush_cnt_reg + 2'd1;
      end
      if (flush_done && cs_s) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a frame runs from a CS falling edge to a CS rising edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (frame_start) state_next = ST_RECEIVE;
      ST_RECEIVE: if (cs_rise)     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    frame_active = 1'b0;
    if (state_reg == ST_RECEIVE) begin
      frame_active = 1'b1;
    end
  end

  // Shift register, bit/byte counters and the strobed outputs. A CS rise beats a
  // coincident sample edge, and the edge that coincides with the CS fall is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      data_reg       <= '0;
      data_vld_reg   <= 1'b0;
      byte_count_reg <= '0;
      frame_err_reg  <= 1'b0;
    end else begin
      data_vld_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      if (state_reg == ST_IDLE) begin
        if (frame_start) begin
          shift_reg      <= '0;
          bit_cnt_reg    <= '0;
          byte_count_reg <= '0;
        end
      end else if (cs_rise) begin
        if (bit_cnt_reg != 3'd0) begin
          frame_err_reg <= 1'b1;
        end
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
      end else if (sample_edge) begin
        shift_reg   <= {shift_reg[6:0], mosi_s};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          data_reg     <= {shift_reg[6:0], mosi_s};
          data_vld_reg <= 1'b1;
          if (byte_count_reg != 8'hFF) begin
            byte_count_reg <= byte_count_reg + 8'd1;
          end
        end
      end
    end
  end

  assign bus.data_o                  = data_reg;
  assign bus.data_out_valid_strobe_o = data_vld_reg;
  assign bus.frame_active_o          = frame_active;
  assign bus.byte_count_o            = byte_count_reg;
  assign bus.frame_error_strobe_o    = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_only_rx_single_cs.sv
// Bench for the receive-only SPI slave: one instance per SPI mode, a byte
// scoreboard filled as frames are driven and drained on each data strobe.
module tb_spi_slave_only_rx_single_cs;

  localparam int HALF = 4;  // SCLK half-period in clk cycles (SCLK = clk/8)

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] sclk_drv;
  logic [3:0] mosi_drv;
  logic [3:0] cs_drv;

  logic [7:0] data_w [4];
  logic [7:0] cnt_w  [4];
  logic [3:0] vld_w;
  logic [3:0] act_w;
  logic [3:0] err_w;

  int         checks;
  int         errors;
  int         cycle_no;
  int         last_sample_cycle;
  int         last_latency;
  int         strobe_seen [4];
  int         err_seen    [4];
  logic [7:0] exp_data    [4];
  int         exp_cnt     [4];
  exp_t       exp_q [$];

  for (genvar gi = 0; gi < 4; gi++) begin : g_mode
    spi_slave_only_rx_single_cs_if bus ();

    assign bus.spi_clk_i  = sclk_drv[gi];
    assign bus.spi_mosi_i = mosi_drv[gi];
    assign bus.spi_cs_i   = cs_drv[gi];
    assign data_w[gi]     = bus.data_o;
    assign cnt_w[gi]      = bus.byte_count_o;
    assign vld_w[gi]      = bus.data_out_valid_strobe_o;
    assign act_w[gi]      = bus.frame_active_o;
    assign err_w[gi]      = bus.frame_error_strobe_o;

    spi_slave_only_rx_single_cs #(
      .SPI_MODE    (gi),
      .SYNC_STAGES (2)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles, sampling on the falling clk edge; every data strobe pops the scoreboard.
  task automatic tick(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cycle_no++;
      for (int m = 0; m < 4; m++) begin
        if (err_w[m] === 1'b1) err_seen[m]++;
        if (vld_w[m] === 1'b1) begin
          strobe_seen[m]++;
          last_latency = cycle_no - last_sample_cycle;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected mode %0d: got strobe with data 0x%02h, required no strobe", m, data_w[m]);
          end else begin
            e = exp_q.pop_front();
            if (e.mode !== 2'(m) || e.data !== data_w[m]) begin
              errors++;
              $display("FAIL scoreboard_byte: got mode %0d data 0x%02h, required mode %0d data 0x%02h",
                       m, data_w[m], e.mode, e.data);
            end
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int m = 0; m < 4; m++) begin
      exp_data[m] = 8'h00;
      exp_cnt[m]  = 0;
    end
  endtask

  task automatic cs_low(input int m);
    cs_drv[m]  = 1'b0;
    exp_cnt[m] = 0;
    tick(HALF);
  endtask

  task automatic cs_high(input int m);
    tick(HALF);
    cs_drv[m] = 1'b1;
    tick(6);
  endtask

  // Send the low n bits of v, MSB first, with mode-correct launch/sample edges.
  task automatic send_bits(input int m, input logic [7:0] v, input int n);
    logic cpha;
    cpha = (m % 2) == 1;
    for (int b = n - 1; b >= 0; b--) begin
      if (!cpha) begin
        mosi_drv[m] = v[b];
        tick(HALF);
        sclk_drv[m] = ~sclk_drv[m];
        last_sample_cycle = cycle_no;
        tick(HALF);
        sclk_drv[m] = ~sclk_drv[m];
      end else begin
        sclk_drv[m] = ~sclk_drv[m];
        mosi_drv[m] = v[b];
        tick(HALF);
        sclk_drv[m] = ~sclk_drv[m];
        last_sample_cycle = cycle_no;
        tick(HALF);
      end
    end
  endtask

  task automatic send_byte(input int m, input logic [7:0] v);
    exp_q.push_back({2'(m), v});
    send_bits(m, v, 8);
    exp_data[m] = v;
    if (exp_cnt[m] < 255) exp_cnt[m]++;
  endtask

  task automatic test_reset();
    do_reset();
    tick(2);
    for (int m = 0; m < 4; m++) begin
      checks += 5;
      if (data_w[m] !== 8'h00) begin errors++; $display("FAIL reset_data mode %0d: got 0x%02h, required 0x00", m, data_w[m]); end
      if (cnt_w[m] !== 8'h00) begin errors++; $display("FAIL reset_count mode %0d: got %0d, required 0", m, cnt_w[m]); end
      if (act_w[m] !== 1'b0) begin errors++; $display("FAIL reset_active mode %0d: got %b, required 0", m, act_w[m]); end
      if (vld_w[m] !== 1'b0) begin errors++; $display("FAIL reset_strobe mode %0d: got %b, required 0", m, vld_w[m]); end
      if (err_w[m] !== 1'b0) begin errors++; $display("FAIL reset_error mode %0d: got %b, required 0", m, err_w[m]); end
    end
    tick(4);
  endtask

  task automatic test_single_byte();
    int s0, e0;
    s0 = strobe_seen[0];
    e0 = err_seen[0];
    cs_low(0);
    checks++;
    if (act_w[0] !== 1'b1) begin errors++; $display("FAIL single_active_rise: got %b, required 1", act_w[0]); end
    send_byte(0, 8'hA5);
    tick(HALF);
    cs_drv[0] = 1'b1;
    tick(2);
    checks++;
    if (act_w[0] !== 1'b1) begin errors++; $display("FAIL single_active_hold: got %b, required 1 two cycles after CS rise", act_w[0]); end
    tick(1);
    checks++;
    if (act_w[0] !== 1'b0) begin errors++; $display("FAIL single_active_fall: got %b, required 0 three cycles after CS rise", act_w[0]); end
    tick(4);
    checks += 4;
    if (strobe_seen[0] - s0 != 1) begin errors++; $display("FAIL single_strobes: got %0d, required 1", strobe_seen[0] - s0); end
    if (err_seen[0] - e0 != 0) begin errors++; $display("FAIL single_error: got %0d, required 0", err_seen[0] - e0); end
    if (data_w[0] !== exp_data[0]) begin errors++; $display("FAIL single_data: got 0x%02h, required 0x%02h", data_w[0], exp_data[0]); end
    if (cnt_w[0] !== 8'(exp_cnt[0])) begin errors++; $display("FAIL single_count: got %0d, required %0d", cnt_w[0], exp_cnt[0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [2];
    int s0;
    bytes[0] = 8'h3C;
    bytes[1] = 8'hC3;
    s0 = strobe_seen[0];
    cs_low(0);
    for (int i = 0; i < 2; i++) begin
      send_byte(0, bytes[i]);
      checks += 2;
      if (last_latency != 3) begin errors++; $display("FAIL b2b_latency byte %0d: got %0d cycles, required 3", i, last_latency); end
      if (data_w[0] !== bytes[i]) begin errors++; $display("FAIL b2b_data byte %0d: got 0x%02h, required 0x%02h", i, data_w[0], bytes[i]); end
    end
    cs_high(0);
    checks += 2;
    if (strobe_seen[0] - s0 != 2) begin errors++; $display("FAIL b2b_strobes: got %0d, required 2", strobe_seen[0] - s0); end
    if (cnt_w[0] !== 8'(exp_cnt[0])) begin errors++; $display("FAIL b2b_count: got %0d, required %0d", cnt_w[0], exp_cnt[0]); end
  endtask

  task automatic test_modes();
    int modes [3];
    int s0;
    modes[0] = 3;
    modes[1] = 1;
    modes[2] = 2;
    for (int i = 0; i < 3; i++) begin
      s0 = strobe_seen[modes[i]];
      cs_low(modes[i]);
      send_byte(modes[i], 8'h81);
      cs_high(modes[i]);
      checks += 3;
      if (data_w[modes[i]] !== 8'h81) begin errors++; $display("FAIL mode_data mode %0d: got 0x%02h, required 0x81", modes[i], data_w[modes[i]]); end
      if (strobe_seen[modes[i]] - s0 != 1) begin errors++; $display("FAIL mode_strobes mode %0d: got %0d, required 1", modes[i], strobe_seen[modes[i]] - s0); end
      if (cnt_w[modes[i]] !== 8'(exp_cnt[modes[i]])) begin errors++; $display("FAIL mode_count mode %0d: got %0d, required %0d", modes[i], cnt_w[modes[i]], exp_cnt[modes[i]]); end
    end
  endtask

  task automatic test_partial_byte();
    int s0, e0;
    s0 = strobe_seen[0];
    e0 = err_seen[0];
    cs_low(0);
    send_bits(0, 8'h16, 5);
    cs_high(0);
    checks += 3;
    if (err_seen[0] - e0 != 1) begin errors++; $display("FAIL partial_error: got %0d pulses, required 1", err_seen[0] - e0); end
    if (strobe_seen[0] - s0 != 0) begin errors++; $display("FAIL partial_strobes: got %0d, required 0", strobe_seen[0] - s0); end
    if (data_w[0] !== exp_data[0]) begin errors++; $display("FAIL partial_data_hold: got 0x%02h, required 0x%02h", data_w[0], exp_data[0]); end
    cs_low(0);
    send_byte(0, 8'h7E);
    cs_high(0);
    checks += 3;
    if (data_w[0] !== 8'h7E) begin errors++; $display("FAIL partial_next_data: got 0x%02h, required 0x7E", data_w[0]); end
    if (cnt_w[0] !== 8'(exp_cnt[0])) begin errors++; $display("FAIL partial_next_count: got %0d, required %0d", cnt_w[0], exp_cnt[0]); end
    if (err_seen[0] - e0 != 1) begin errors++; $display("FAIL partial_next_error: got %0d pulses, required 1", err_seen[0] - e0); end
  endtask

  task automatic test_idle_activity();
    int s0, e0;
    s0 = strobe_seen[0];
    e0 = err_seen[0];
    for (int i = 0; i < 16; i++) begin
      mosi_drv[0] = 1'($urandom_range(0, 1));
      sclk_drv[0] = ~sclk_drv[0];
      tick(HALF);
    end
    checks += 5;
    if (strobe_seen[0] - s0 != 0) begin errors++; $display("FAIL idle_strobes: got %0d, required 0", strobe_seen[0] - s0); end
    if (err_seen[0] - e0 != 0) begin errors++; $display("FAIL idle_error: got %0d, required 0", err_seen[0] - e0); end
    if (data_w[0] !== exp_data[0]) begin errors++; $display("FAIL idle_data: got 0x%02h, required 0x%02h", data_w[0], exp_data[0]); end
    if (cnt_w[0] !== 8'(exp_cnt[0])) begin errors++; $display("FAIL idle_count: got %0d, required %0d", cnt_w[0], exp_cnt[0]); end
    if (act_w[0] !== 1'b0) begin errors++; $display("FAIL idle_active: got %b, required 0", act_w[0]); end
  endtask

  task automatic test_reset_mid_frame();
    int s0, e0;
    cs_low(0);
    send_bits(0, 8'h0F, 4);
    do_reset();
    s0 = strobe_seen[0];
    e0 = err_seen[0];
    tick(2);
    checks++;
    if (act_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_active: got %b, required 0 with CS still low", act_w[0]); end
    send_bits(0, 8'h0F, 4);
    tick(HALF);
    cs_drv[0] = 1'b1;
    tick(6);
    checks += 4;
    if (strobe_seen[0] - s0 != 0) begin errors++; $display("FAIL midreset_strobes: got %0d, required 0", strobe_seen[0] - s0); end
    if (err_seen[0] - e0 != 0) begin errors++; $display("FAIL midreset_error: got %0d, required 0", err_seen[0] - e0); end
    if (data_w[0] !== 8'h00) begin errors++; $display("FAIL midreset_data: got 0x%02h, required 0x00", data_w[0]); end
    if (cnt_w[0] !== 8'h00) begin errors++; $display("FAIL midreset_count: got %0d, required 0", cnt_w[0]); end
    cs_low(0);
    send_byte(0, 8'h12);
    cs_high(0);
    checks += 2;
    if (data_w[0] !== 8'h12) begin errors++; $display("FAIL midreset_next_data: got 0x%02h, required 0x12", data_w[0]); end
    if (cnt_w[0] !== 8'd1) begin errors++; $display("FAIL midreset_next_count: got %0d, required 1", cnt_w[0]); end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    cycle_no          = 0;
    last_sample_cycle = 0;
    last_latency      = 0;
    for (int m = 0; m < 4; m++) begin
      strobe_seen[m] = 0;
      err_seen[m]    = 0;
      exp_data[m]    = 8'h00;
      exp_cnt[m]     = 0;
    end
    sclk_drv = 4'b1100;  // modes 2 and 3 idle with SCLK high
    mosi_drv = 4'b0000;
    cs_drv   = 4'b1111;
    rst      = 1'b1;

    test_reset();
    test_single_byte();
    test_back_to_back();
    test_modes();
    test_partial_byte();
    test_idle_activity();
    test_reset_mid_frame();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d bytes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
